// File: rtl/nou_noc_tx_arb.sv
// Outbound NoC data arbiter: round-robin packet merge of NUM_CH producer streams with
// grant lock until last beat, packet-length cap and a 2-entry output skid buffer.
module nou_noc_tx_arb #(
  parameter int NUM_CH        = 4,
  parameter int TID_W         = 8,
  parameter int TYPE_W        = 2,
  parameter int DATA_W        = 256,
  parameter int MAX_PKT_BEATS = 16,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     nou_clk,
  input  logic                     nou_rst,
  input  logic [NUM_CH-1:0]        ch_vld,
  output logic [NUM_CH-1:0]        ch_rdy,
  input  logic [NUM_CH*TID_W-1:0]  ch_tid,
  input  logic [NUM_CH*TYPE_W-1:0] ch_type,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_last,
  output logic                     nou_noc_data_vld,
  input  logic                     noc_nou_data_rdy,
  output logic [TID_W-1:0]         nou_noc_data_tid,
  output logic [TYPE_W-1:0]        nou_noc_data_type,
  output logic [DATA_W-1:0]        nou_noc_data,
  output logic                     nou_noc_data_last,
  output logic [CH_W-1:0]          nou_noc_data_chid,
  output logic                     arb_busy,
  output logic                     err_pkt_len
);

  localparam int BC_W = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [CH_W-1:0]   chid;
    logic [TID_W-1:0]  tid;
    logic [TYPE_W-1:0] typ;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CH_W-1:0]   lock_ch_reg, lock_ch_next;
  logic [BC_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic              err_reg, err_next;

  beat_t             skid_mem [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        skid_cnt_reg;

  logic [TID_W-1:0]  tid_arr  [NUM_CH];
  logic [TYPE_W-1:0] type_arr [NUM_CH];
  logic [DATA_W-1:0] data_arr [NUM_CH];

  logic              found_hi, found_lo, found;
  logic [CH_W-1:0]   grant_hi, grant_lo, grant;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_last;
  logic [BC_W-1:0]   beat_num;
  logic              forced, eff_last;
  logic              space, accept, pop, out_vld;
  beat_t             new_beat, head;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign tid_arr[gi]  = ch_tid[gi*TID_W +: TID_W];
    assign type_arr[gi] = ch_type[gi*TYPE_W +: TYPE_W];
    assign data_arr[gi] = ch_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin search: first requester at or above rr_ptr, else first one below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_vld[c] && (c >= int'(rr_ptr_reg)) && !found_hi) begin
        found_hi = 1'b1;
        grant_hi = CH_W'(c);
      end
      if (ch_vld[c] && (c < int'(rr_ptr_reg)) && !found_lo) begin
        found_lo = 1'b1;
        grant_lo = CH_W'(c);
      end
    end
    found = found_hi || found_lo;
    grant = found_hi ? grant_hi : grant_lo;
  end

  // Ready depends only on registered state so it never loops through the NoC ready.
  assign space = (skid_cnt_reg != 2'd2);

  always_comb begin
    ch_rdy = '0;
    if (!nou_rst && space) begin
      if (state_reg == IDLE) begin
        if (found) ch_rdy[grant] = 1'b1;
      end else begin
        ch_rdy[lock_ch_reg] = 1'b1;
      end
    end
  end

  assign accept   = |(ch_vld & ch_rdy);
  assign sel_ch   = (state_reg == IDLE) ? grant : lock_ch_reg;
  assign sel_last = ch_last[sel_ch];
  assign beat_num = (state_reg == IDLE) ? BC_W'(1) : beat_cnt_reg + 1'b1;
  assign forced   = !sel_last && (beat_num == BC_W'(MAX_PKT_BEATS));
  assign eff_last = sel_last || forced;

  always_comb begin
    new_beat      = '0;
    new_beat.chid = sel_ch;
    new_beat.tid  = tid_arr[sel_ch];
    new_beat.typ  = type_arr[sel_ch];
    new_beat.data = data_arr[sel_ch];
    new_beat.last = eff_last;
  end

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    lock_ch_next  = lock_ch_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        beat_cnt_next = '0;
        if (accept) begin
          rr_ptr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
          if (!eff_last) begin
            state_next    = LOCKED;
            lock_ch_next  = grant;
            beat_cnt_next = beat_num;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          if (eff_last) begin
            state_next    = IDLE;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_num;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (accept && forced) err_next = 1'b1;
  end

  always_ff @(posedge nou_clk) begin
    if (nou_rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      lock_ch_reg  <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      lock_ch_reg  <= lock_ch_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
    end
  end

  assign out_vld = (skid_cnt_reg != 2'd0);
  assign pop     = out_vld && noc_nou_data_rdy;

  always_ff @(posedge nou_clk) begin
    if (accept) skid_mem[wr_ptr_reg] <= new_beat;
  end

  always_ff @(posedge nou_clk) begin
    if (nou_rst) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      skid_cnt_reg <= 2'd0;
    end else begin
      if (accept) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)    rd_ptr_reg <= ~rd_ptr_reg;
      case ({accept, pop})
        2'b10:   skid_cnt_reg <= skid_cnt_reg + 2'd1;
        2'b01:   skid_cnt_reg <= skid_cnt_reg - 2'd1;
        default: skid_cnt_reg <= skid_cnt_reg;
      endcase
    end
  end

  // Payload is gated by valid so an empty buffer presents all-zero outputs.
  assign head              = skid_mem[rd_ptr_reg];
  assign nou_noc_data_vld  = out_vld;
  assign nou_noc_data_tid  = out_vld ? head.tid  : '0;
  assign nou_noc_data_type = out_vld ? head.typ  : '0;
  assign nou_noc_data      = out_vld ? head.data : '0;
  assign nou_noc_data_last = out_vld ? head.last : 1'b0;
  assign nou_noc_data_chid = out_vld ? head.chid : '0;

  assign arb_busy    = (state_reg == LOCKED) || out_vld;
  assign err_pkt_len = err_reg;

endmodule
